tzn_iter: RTL and testbench
===========================

# tzn_iter

Parametrised, iterative trailing/leading-zero counter with a valid/ready handshake on both sides. The operand is scanned one SEG-bit segment per cycle and the scan stops at the first nonzero segment, so narrow logic serves wide operands. It serves the GCD datapath's normalisation step, the priority-encode paths, and any other block that needs a zero count wider than 16 bits.

## Interface
- WIDTH, 32: operand width; power of two, ≥ 2.
- SEG, 8: segment width scanned per cycle; power of two, divides WIDTH, 1 ≤ SEG ≤ WIDTH. NSEG = WIDTH/SEG.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- valid_i  in  1  request valid.
- ready_o  out  1  block can accept a request (high only in IDLE, low while rst_i is high).
- a_i  in  WIDTH  operand; sampled only on an accept.
- lead_i  in  1  mode: 0 counts trailing zeros, 1 counts leading zeros; sampled only on an accept.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- numz_o  out  $clog2(WIDTH)+1  zero count, 0..WIDTH.
- all_zeros_o  out  1  operand was all zeros (numz_o == WIDTH).

## Operation
- Accept: valid_i && ready_o at a rising edge.
- Result handoff: valid_o && ready_i at a rising edge.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - ready_o = 1.
  - On accept: register the operand. When lead_i = 1, register it bit-reversed, so both modes run as a trailing scan. Clear seg index to 0. Go to SCAN.
- SCAN:
  - ready_o = 0. Examine segment idx, bits [idx*SEG +: SEG] of the registered operand.
  - If the segment is nonzero: numz_o ← idx*SEG + tz(segment), all_zeros_o ← 0, go to DONE.
  - Else if idx == NSEG−1: numz_o ← WIDTH, all_zeros_o ← 1, go to DONE.
  - Else: idx ← idx+1.
- DONE:
  - valid_o = 1; numz_o and all_zeros_o stay stable.
  - On ready_i: go to IDLE.
  - A new request is not accepted in the same cycle as a result handoff.
- Ignored inputs:
  - valid_i, a_i and lead_i are ignored outside IDLE.
  - ready_i is ignored outside DONE.
- Width rules:
  - idx is $clog2(NSEG) bits, minimum 1.
  - Count arithmetic is done at $clog2(WIDTH)+1 bits with no truncation; WIDTH is representable.
- SEG == WIDTH degenerates to a single-cycle scan; behaviour is otherwise identical.
- numz_o and all_zeros_o hold their last written value until the next result; they are meaningful only while valid_o = 1.

## Timing
- Reset (rst_i high at an edge):
  - Next state: FSM = IDLE, idx = 0, valid_o = 0, numz_o = 0, all_zeros_o = 0.
  - ready_o = 0 while rst_i is high, and 1 from the first cycle after release.
- Reset mid-SCAN or mid-DONE: the operation is aborted and no result is produced. It overrides any simultaneous accept or handoff.
- Latency: accept at edge E0, first nonzero segment index k (k = NSEG−1 for zero operands). valid_o rises after edge E0+k+1.
  - Minimum latency is 1 cycle.
  - Maximum latency is NSEG cycles.
- valid_o stays high for as many cycles as ready_i stays low; there is no timeout.
- After the handoff edge, ready_o is high in the next cycle. Back-to-back issue interval is k+3 cycles.
- All outputs are registered or decoded from FSM state only; there is no combinational path from valid_i or ready_i to any output.

## Test plan
- WIDTH=32, SEG=8, trailing, a=0x0000_0001 → numz_o=0, all_zeros_o=0, valid_o 1 cycle after accept.
- a=0x8000_0000:
  - trailing → numz_o=31, valid_o 4 cycles after accept.
  - leading → numz_o=0, 1 cycle after accept.
  - a=0x0001_0000 leading → 15.
- a=0 in both modes → numz_o=32, all_zeros_o=1, valid_o 4 cycles after accept.
- Backpressure: a=0x0000_0100 trailing, hold ready_i=0 for 5 cycles → valid_o=1 and numz_o=8 stable throughout. valid_i pulses during SCAN/DONE change nothing. After ready_i, ready_o=1 next cycle.
- Reset mid-SCAN of 0x0100_0000 (in cycle 2) → valid_o never rises, all outputs reset, ready_o=1 after release. A following request a=0x0000_0100 → numz_o=8.
- Randomised operands and modes, checked against a reference model, for three configurations:
  - WIDTH=32, SEG=8.
  - WIDTH=16, SEG=4.
  - WIDTH=64, SEG=64 (1-cycle latency).
  - Each with random ready_i stalls; results must match in order.

Source files
------------

// File: rtl/tzn_iter.sv
// rtl/tzn_iter.sv - iterative segment-serial trailing/leading zero counter
//
// Scans the operand one SEG-bit segment per cycle, stopping at the first
// nonzero segment. Leading-zero requests are bit-reversed on accept so the
// scan engine only ever counts trailing zeros.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   valid_i      request valid
//   ready_o      request can be accepted (IDLE and not in reset)
//   a_i          operand, sampled on accept
//   lead_i       0 = trailing zeros, 1 = leading zeros, sampled on accept
//   valid_o      result valid (DONE)
//   ready_i      consumer takes the result
//   numz_o       zero count, 0..WIDTH
//   all_zeros_o  operand was all zeros
module tzn_iter #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [WIDTH-1:0]         a_i,
  input  logic                     lead_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(WIDTH):0]   numz_o,
  output logic                     all_zeros_o
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int CW   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   numz_q, numz_d;
  logic            az_q, az_d;

  logic [WIDTH-1:0] a_rev;
  logic [CW-1:0]    seg_base;
  logic [SEG-1:0]   seg;
  logic [CW-1:0]    seg_tz;
  logic             seg_nz;
  logic             last_seg;

  always_comb begin
    a_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      a_rev[i] = a_i[WIDTH-1-i];
    end
  end

  // Count arithmetic stays at CW bits; (NSEG-1)*SEG + (SEG-1) < WIDTH fits.
  assign seg_base = CW'(idx_q) * CW'(SEG);
  assign seg      = SEG'(opnd_q >> seg_base);
  assign seg_nz   = |seg;
  assign last_seg = (idx_q == IW'(NSEG - 1));

  // Scan from the top bit down so the lowest set bit is the one that sticks.
  always_comb begin
    seg_tz = '0;
    for (int i = SEG - 1; i >= 0; i--) begin
      if (seg[i]) seg_tz = CW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    opnd_d  = opnd_q;
    numz_d  = numz_q;
    az_d    = az_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          opnd_d  = lead_i ? a_rev : a_i;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (seg_nz) begin
          numz_d  = seg_base + seg_tz;
          az_d    = 1'b0;
          state_d = DONE;
        end else if (last_seg) begin
          numz_d  = CW'(WIDTH);
          az_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      opnd_q  <= '0;
      numz_q  <= '0;
      az_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      opnd_q  <= opnd_d;
      numz_q  <= numz_d;
      az_q    <= az_d;
    end
  end

  assign ready_o     = (state_q == IDLE) && !rst_i;
  assign valid_o     = (state_q == DONE);
  assign numz_o      = numz_q;
  assign all_zeros_o = az_q;

endmodule

// File: tb/tb_tzn_iter.sv
// tb/tb_tzn_iter.sv - table-driven bench for tzn_iter in three configurations
//
// cfg 0: WIDTH=32 SEG=8, cfg 1: WIDTH=16 SEG=4, cfg 2: WIDTH=64 SEG=64.
// One shared stimulus bus is steered to the selected instance.
module tb_tzn_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, lead, rdy;
  logic [63:0] a;
  int          cfg;

  logic       v0, v1, v2, r0, r1, r2;
  logic       ro0, ro1, ro2, vo0, vo1, vo2, az0, az1, az2;
  logic [5:0] nz0;
  logic [4:0] nz1;
  logic [6:0] nz2;

  logic ready_m, valid_m, az_m;
  int   numz_m;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign v0 = valid && (cfg == 0);
  assign v1 = valid && (cfg == 1);
  assign v2 = valid && (cfg == 2);
  assign r0 = rdy && (cfg == 0);
  assign r1 = rdy && (cfg == 1);
  assign r2 = rdy && (cfg == 2);

  tzn_iter #(.WIDTH(32), .SEG(8)) u0 (
    .clk_i(clk), .rst_i(rst), .valid_i(v0), .ready_o(ro0), .a_i(a[31:0]),
    .lead_i(lead), .valid_o(vo0), .ready_i(r0), .numz_o(nz0), .all_zeros_o(az0));
  tzn_iter #(.WIDTH(16), .SEG(4)) u1 (
    .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(ro1), .a_i(a[15:0]),
    .lead_i(lead), .valid_o(vo1), .ready_i(r1), .numz_o(nz1), .all_zeros_o(az1));
  tzn_iter #(.WIDTH(64), .SEG(64)) u2 (
    .clk_i(clk), .rst_i(rst), .valid_i(v2), .ready_o(ro2), .a_i(a),
    .lead_i(lead), .valid_o(vo2), .ready_i(r2), .numz_o(nz2), .all_zeros_o(az2));

  always_comb begin
    ready_m = ro0; valid_m = vo0; az_m = az0; numz_m = int'(nz0);
    case (cfg)
      1: begin ready_m = ro1; valid_m = vo1; az_m = az1; numz_m = int'(nz1); end
      2: begin ready_m = ro2; valid_m = vo2; az_m = az2; numz_m = int'(nz2); end
      default: ;
    endcase
  end

  typedef struct {
    int          cfg;
    logic [63:0] a;
    bit          lead;
    int          stall;
    int          nz;
    bit          az;
    int          lat;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cfg %0d, t=%0t)", name, act, exp, cfg, $time);
    end
  endtask

  function automatic int ref_nz(input logic [63:0] op, input int w, input bit ld);
    for (int i = 0; i < w; i++) begin
      int b;
      b = ld ? (w - 1 - i) : i;
      if (op[b]) return i;
    end
    return w;
  endfunction

  task automatic run_req(input int c, input logic [63:0] op, input bit ld, input int stall,
                         input int exp_nz, input bit exp_az, input int exp_lat);
    int lat;
    @(negedge clk);
    cfg = c;
    #0;
    check("ready_before", ready_m, 1);
    valid = 1'b1; a = op; lead = ld;
    @(posedge clk);
    #1;
    valid = 1'b0; a = ~op; lead = ~ld;
    lat = 0;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_m) begin
        lat = i;
        break;
      end
    end
    check("latency", lat, exp_lat);
    check("numz", numz_m, exp_nz);
    check("all_zeros", az_m, exp_az);
    // Requests offered while busy must be ignored.
    valid = 1'b1; a = {$urandom, $urandom}; lead = ~ld;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", valid_m, 1);
      check("hold_numz", numz_m, exp_nz);
      check("hold_ready", ready_m, 0);
    end
    rdy = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("ready_after", ready_m, 1);
    check("valid_after", valid_m, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, sg, nz, lat;
    logic [63:0] op, mask;
    bit ld;

    tbl[0]  = '{0, 64'h0000_0001, 1'b0, 0,  0, 1'b0, 1};
    tbl[1]  = '{0, 64'h8000_0000, 1'b0, 0, 31, 1'b0, 4};
    tbl[2]  = '{0, 64'h8000_0000, 1'b1, 0,  0, 1'b0, 1};
    tbl[3]  = '{0, 64'h0001_0000, 1'b1, 0, 15, 1'b0, 2};
    tbl[4]  = '{0, 64'h0,         1'b0, 0, 32, 1'b1, 4};
    tbl[5]  = '{0, 64'h0,         1'b1, 1, 32, 1'b1, 4};
    tbl[6]  = '{1, 64'h0010,      1'b0, 0,  4, 1'b0, 2};
    tbl[7]  = '{1, 64'h8000,      1'b1, 2,  0, 1'b0, 1};
    tbl[8]  = '{1, 64'h0,         1'b0, 0, 16, 1'b1, 4};
    tbl[9]  = '{1, 64'h0100,      1'b1, 0,  7, 1'b0, 2};
    tbl[10] = '{2, 64'h8000_0000_0000_0000, 1'b0, 0, 63, 1'b0, 1};
    tbl[11] = '{2, 64'h0,         1'b1, 1, 64, 1'b1, 1};
    tbl[12] = '{2, 64'h1,         1'b1, 0, 63, 1'b0, 1};
    tbl[13] = '{0, 64'h0000_0100, 1'b0, 5,  8, 1'b0, 2};

    rst = 1'b1; valid = 1'b0; rdy = 1'b0; a = '0; lead = 1'b0; cfg = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready0", ro0, 0);
    check("rst_ready2", ro2, 0);
    check("rst_valid", valid_m, 0);
    check("rst_numz", numz_m, 0);
    check("rst_az", az_m, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rel_ready0", ro0, 1);
    check("rel_ready1", ro1, 1);

    foreach (tbl[i])
      run_req(tbl[i].cfg, tbl[i].a, tbl[i].lead, tbl[i].stall, tbl[i].nz, tbl[i].az, tbl[i].lat);

    // Reset in the second scan cycle of a 4-segment scan aborts it.
    cfg = 0;
    @(negedge clk);
    valid = 1'b1; a = 64'h0100_0000; lead = 1'b0;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_ready", ready_m, 0);
    check("mid_rst_valid", valid_m, 0);
    check("mid_rst_numz", numz_m, 0);
    check("mid_rst_az", az_m, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", ready_m, 1);
    begin
      bit rose;
      rose = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (valid_m) rose = 1'b1;
      end
      check("post_rst_no_valid", rose, 0);
    end
    run_req(0, 64'h0000_0100, 1'b0, 0, 8, 1'b0, 2);

    // Random operands against the reference model.
    for (int c = 0; c < 3; c++) begin
      w  = (c == 0) ? 32 : (c == 1) ? 16 : 64;
      sg = (c == 0) ? 8  : (c == 1) ? 4  : 64;
      mask = (w == 64) ? '1 : ((64'h1 << w) - 64'h1);
      for (int n = 0; n < 25; n++) begin
        op = {$urandom, $urandom};
        op = (op >> $urandom_range(0, 63)) << $urandom_range(0, 63);
        if ($urandom_range(0, 7) == 0) op = '0;
        op = op & mask;
        ld = 1'($urandom_range(0, 1));
        nz = ref_nz(op, w, ld);
        lat = (nz == w) ? (w / sg) : (nz / sg + 1);
        run_req(c, op, ld, $urandom_range(0, 3), nz, (nz == w), lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
